// File: rtl/cmos_capture_pix.sv
// CMOS DVP capture front end: frame skip, beat packing, run-time crop and
// frame-boundary capture control, all in the cam_pclk domain.
module cmos_capture_pix #(
  parameter int DW         = 8,
  parameter int BPP        = 2,
  parameter int WAIT_FRAME = 10,
  parameter int MSB_FIRST  = 1,
  parameter int XW         = 12
) (
  input  logic               cam_pclk,
  input  logic               rst,
  input  logic               cam_vsync,
  input  logic               cam_href,
  input  logic [DW-1:0]      cam_data,
  input  logic               cap_en,
  input  logic [XW-1:0]      crop_x0,
  input  logic [XW-1:0]      crop_y0,
  input  logic [XW-1:0]      crop_w,
  input  logic [XW-1:0]      crop_h,
  output logic               cmos_frame_vsync,
  output logic               cmos_frame_href,
  output logic               cmos_frame_valid,
  output logic [DW*BPP-1:0]  cmos_frame_data,
  output logic [XW-1:0]      pix_x,
  output logic [XW-1:0]      pix_y,
  output logic               frame_start,
  output logic               frame_end,
  output logic [15:0]        frame_cnt,
  output logic               err_beats
);

  localparam int BCW = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int WCW = $clog2(WAIT_FRAME + 2);

  typedef enum logic [1:0] {S_WAIT, S_ARMED, S_ACTIVE} state_t;

  state_t              r_state, w_state_nxt;
  logic [WCW-1:0]      r_wcnt, w_wcnt_nxt;
  logic                w_start, w_end;

  logic                r_vs1, r_vs1_d, r_hs1, r_cap1;
  logic [DW-1:0]       r_d1;
  logic [XW-1:0]       r_cx0_1, r_cy0_1, r_cw_1, r_ch_1;
  logic [XW-1:0]       r_sx0, r_sy0, r_sw, r_sh;

  logic [BCW-1:0]      r_bc;
  logic [DW*BPP-1:0]   r_acc, w_acc;
  logic [XW-1:0]       r_x, r_y, r_rx, r_ry;
  logic                r_line_pix, r_pv;

  logic                w_vs_rise, w_last, w_in_x, w_in_y;
  int unsigned         w_slice;

  assign w_vs_rise = r_vs1 & ~r_vs1_d;
  assign w_last    = r_hs1 && (r_bc == BCW'(BPP - 1));
  assign w_in_x    = (r_x >= r_sx0) &&
                     ((r_sw == '0) || ({1'b0, r_x} < ({1'b0, r_sx0} + {1'b0, r_sw})));
  assign w_in_y    = (r_y >= r_sy0) &&
                     ((r_sh == '0) || ({1'b0, r_y} < ({1'b0, r_sy0} + {1'b0, r_sh})));

  // Once the skip count is reached, WAIT behaves like ARMED so WAIT_FRAME=0 skips nothing.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_start     = 1'b0;
    w_end       = 1'b0;
    if (w_vs_rise) begin
      unique case (r_state)
        S_WAIT: begin
          if (r_wcnt == WCW'(WAIT_FRAME)) begin
            w_state_nxt = r_cap1 ? S_ACTIVE : S_ARMED;
            w_start     = r_cap1;
          end else begin
            w_wcnt_nxt = r_wcnt + 1'b1;
            if ((r_wcnt + 1'b1) == WCW'(WAIT_FRAME)) w_state_nxt = S_ARMED;
          end
        end
        S_ARMED: begin
          if (r_cap1) begin
            w_state_nxt = S_ACTIVE;
            w_start     = 1'b1;
          end
        end
        S_ACTIVE: begin
          w_end       = 1'b1;
          w_start     = r_cap1;
          w_state_nxt = r_cap1 ? S_ACTIVE : S_ARMED;
        end
        default: w_state_nxt = S_WAIT;
      endcase
    end
  end

  always_comb begin
    w_acc   = r_acc;
    w_slice = (MSB_FIRST != 0) ? (BPP - 1 - int'(r_bc)) : int'(r_bc);
    for (int unsigned i = 0; i < BPP; i++) begin
      if (i == w_slice) w_acc[i*DW +: DW] = r_d1;
    end
  end

  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      r_state          <= S_WAIT;
      r_wcnt           <= '0;
      r_vs1            <= 1'b0;
      r_vs1_d          <= 1'b0;
      r_hs1            <= 1'b0;
      r_cap1           <= 1'b0;
      r_d1             <= '0;
      r_cx0_1          <= '0;
      r_cy0_1          <= '0;
      r_cw_1           <= '0;
      r_ch_1           <= '0;
      r_sx0            <= '0;
      r_sy0            <= '0;
      r_sw             <= '0;
      r_sh             <= '0;
      r_bc             <= '0;
      r_acc            <= '0;
      r_x              <= '0;
      r_y              <= '0;
      r_rx             <= '0;
      r_ry             <= '0;
      r_line_pix       <= 1'b0;
      r_pv             <= 1'b0;
      cmos_frame_vsync <= 1'b0;
      cmos_frame_href  <= 1'b0;
      cmos_frame_valid <= 1'b0;
      cmos_frame_data  <= '0;
      pix_x            <= '0;
      pix_y            <= '0;
      frame_start      <= 1'b0;
      frame_end        <= 1'b0;
      frame_cnt        <= '0;
      err_beats        <= 1'b0;
    end else begin
      r_vs1   <= cam_vsync;
      r_vs1_d <= r_vs1;
      r_hs1   <= cam_href;
      r_cap1  <= cap_en;
      r_d1    <= cam_data;
      r_cx0_1 <= crop_x0;
      r_cy0_1 <= crop_y0;
      r_cw_1  <= crop_w;
      r_ch_1  <= crop_h;

      r_state     <= w_state_nxt;
      r_wcnt      <= w_wcnt_nxt;
      frame_start <= w_start;
      frame_end   <= w_end;
      if (w_end) frame_cnt <= frame_cnt + 1'b1;
      if (w_start) begin
        r_sx0 <= r_cx0_1;
        r_sy0 <= r_cy0_1;
        r_sw  <= r_cw_1;
        r_sh  <= r_ch_1;
      end

      cmos_frame_vsync <= r_vs1 && (w_state_nxt == S_ACTIVE);
      cmos_frame_href  <= r_hs1 && (r_state == S_ACTIVE) && w_in_y;

      if (r_hs1) begin
        r_acc <= w_acc;
        r_bc  <= w_last ? '0 : r_bc + 1'b1;
      end else begin
        r_bc <= '0;
      end
      if (!r_hs1 && (r_bc != '0)) err_beats <= 1'b1;

      if (!r_hs1)                 r_x <= '0;
      else if (w_last && r_x != '1) r_x <= r_x + 1'b1;

      if (w_vs_rise) begin
        r_y        <= '0;
        r_line_pix <= 1'b0;
      end else if (!r_hs1 && r_line_pix) begin
        r_line_pix <= 1'b0;
        if (r_y != '1) r_y <= r_y + 1'b1;
      end else if (w_last) begin
        r_line_pix <= 1'b1;
      end

      r_pv <= w_last && (r_state == S_ACTIVE) && w_in_x && w_in_y;
      r_rx <= r_x - r_sx0;
      r_ry <= r_y - r_sy0;

      cmos_frame_valid <= r_pv;
      if (r_pv) begin
        cmos_frame_data <= r_acc;
        pix_x           <= r_rx;
        pix_y           <= r_ry;
      end
    end
  end

endmodule

// File: tb/tb_cmos_capture_pix.sv
// Scoreboard bench for cmos_capture_pix: directed frames, crop, packing order,
// partial-pixel error, capture enable and mid-line reset.
module tb_cmos_capture_pix;

  logic        clk = 1'b0;
  logic        rst, vsync, href, cap_en;
  logic [7:0]  data;
  logic [11:0] cx0, cy0, cw, ch;

  logic        o_vs, o_hs, o_v, o_fs, o_fe, o_err;
  logic [15:0] o_d, o_fc;
  logic [11:0] o_px, o_py;
  logic        l_vs, l_hs, l_v, l_fs, l_fe, l_err;
  logic [15:0] l_d, l_fc;
  logic [11:0] l_px, l_py;

  typedef struct {
    logic [15:0] d;
    logic [11:0] x;
    logic [11:0] y;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0, n_errors = 0;
  int   n_fs = 0, n_fe = 0, n_vs = 0, n_href = 0, n_valid = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cmos_capture_pix #(.DW(8), .BPP(2), .WAIT_FRAME(2), .MSB_FIRST(1), .XW(12)) u_dut (
    .cam_pclk(clk), .rst(rst), .cam_vsync(vsync), .cam_href(href), .cam_data(data),
    .cap_en(cap_en), .crop_x0(cx0), .crop_y0(cy0), .crop_w(cw), .crop_h(ch),
    .cmos_frame_vsync(o_vs), .cmos_frame_href(o_hs), .cmos_frame_valid(o_v),
    .cmos_frame_data(o_d), .pix_x(o_px), .pix_y(o_py), .frame_start(o_fs),
    .frame_end(o_fe), .frame_cnt(o_fc), .err_beats(o_err));

  cmos_capture_pix #(.DW(8), .BPP(2), .WAIT_FRAME(2), .MSB_FIRST(0), .XW(12)) u_lsb (
    .cam_pclk(clk), .rst(rst), .cam_vsync(vsync), .cam_href(href), .cam_data(data),
    .cap_en(cap_en), .crop_x0(cx0), .crop_y0(cy0), .crop_w(cw), .crop_h(ch),
    .cmos_frame_vsync(l_vs), .cmos_frame_href(l_hs), .cmos_frame_valid(l_v),
    .cmos_frame_data(l_d), .pix_x(l_px), .pix_y(l_py), .frame_start(l_fs),
    .frame_end(l_fe), .frame_cnt(l_fc), .err_beats(l_err));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected pixel per strobe and checks data, coords and latency.
  always @(negedge clk) begin
    exp_t e;
    if (o_fs) n_fs++;
    if (o_fe) n_fe++;
    if (o_vs) n_vs++;
    if (o_hs) n_href++;
    if (o_v !== l_v) chk("lsb_valid_align", 32'(l_v), 32'(o_v));
    if (o_v) begin
      n_valid++;
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        n_checks++;
        if (o_d !== e.d || l_d !== {e.d[7:0], e.d[15:8]} || o_px !== e.x ||
            o_py !== e.y || cyc != e.cyc) begin
          n_errors++;
          $display("FAIL pixel: got d=%h lsb=%h x=%0d y=%0d cyc=%0d expected d=%h lsb=%h x=%0d y=%0d cyc=%0d",
                   o_d, l_d, o_px, o_py, cyc, e.d, {e.d[7:0], e.d[15:8]}, e.x, e.y, e.cyc);
        end
      end
    end
  end

  task automatic vs_pulse();
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_line(input int nbeats, input logic [7:0] base, input logic [7:0] step,
                           input int ln, input bit cap,
                           input int x0, input int y0, input int w, input int h);
    logic [7:0] d, prev;
    exp_t e;
    int p;
    prev = '0;
    for (int j = 0; j < nbeats; j++) begin
      d = base + 8'(j) * step;
      href = 1'b1;
      data = d;
      if (cap && (j % 2) == 1) begin
        p = j / 2;
        if (p >= x0 && (w == 0 || p < x0 + w) && ln >= y0 && (h == 0 || ln < y0 + h)) begin
          e.d = {prev, d};
          e.x = 12'(p - x0);
          e.y = 12'(ln - y0);
          e.cyc = cyc + 3;
          q.push_back(e);
        end
      end
      prev = d;
      @(negedge clk);
    end
    href = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int hv, nv, vsb;
    rst = 1'b1; vsync = 1'b0; href = 1'b0; data = '0; cap_en = 1'b0;
    cx0 = '0; cy0 = '0; cw = '0; ch = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(o_v), 0);
    chk("rst_vsync", 32'(o_vs), 0);
    chk("rst_cnt", 32'(o_fc), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_data", 32'(o_d), 0);
    rst = 1'b0;
    cap_en = 1'b1;

    for (int f = 0; f < 2; f++) begin
      vs_pulse();
      send_line(4, 8'h10, 8'h01, 0, 1'b0, 0, 0, 0, 0);
      send_line(4, 8'h20, 8'h01, 1, 1'b0, 0, 0, 0, 0);
    end
    chk("wait_no_start", 32'(n_fs), 0);
    chk("wait_no_vsync", 32'(n_vs), 0);
    chk("wait_no_valid", 32'(n_valid), 0);

    vs_pulse();
    chk("f3_start", 32'(n_fs), 1);
    chk("f3_vsync_cycles", 32'(n_vs), 3);
    send_line(2, 8'hAB, 8'h22, 0, 1'b1, 0, 0, 0, 0);
    chk("msb_data", 32'(o_d), 32'h0000ABCD);
    chk("lsb_data", 32'(l_d), 32'h0000CDAB);

    cx0 = 12'd2; cy0 = 12'd1; cw = 12'd3; ch = 12'd2;
    hv = n_href; nv = n_valid;
    vs_pulse();
    chk("f4_frame_cnt", 32'(o_fc), 1);
    chk("f4_frame_end", 32'(n_fe), 1);
    for (int ln = 0; ln < 4; ln++) begin
      send_line(16, 8'(ln * 16), 8'h01, ln, 1'b1, 2, 1, 3, 2);
      if (ln == 0) begin
        cx0 = '0; cy0 = '0; cw = '0; ch = '0;
      end
    end
    chk("crop_valid_count", 32'(n_valid - nv), 6);
    chk("crop_href_cycles", 32'(n_href - hv), 32);

    vs_pulse();
    chk("f5_frame_cnt", 32'(o_fc), 2);
    send_line(5, 8'h40, 8'h01, 0, 1'b1, 0, 0, 0, 0);
    chk("err_set", 32'(o_err), 1);
    send_line(4, 8'h50, 8'h01, 1, 1'b1, 0, 0, 0, 0);
    chk("err_sticky", 32'(o_err), 1);
    cap_en = 1'b0;
    send_line(4, 8'h60, 8'h01, 2, 1'b1, 0, 0, 0, 0);

    nv = n_valid; vsb = n_vs;
    vs_pulse();
    chk("f6_frame_cnt", 32'(o_fc), 3);
    chk("f6_frame_end", 32'(n_fe), 3);
    chk("f6_vsync_gated", 32'(n_vs - vsb), 0);
    send_line(4, 8'h70, 8'h01, 0, 1'b0, 0, 0, 0, 0);
    chk("armed_no_valid", 32'(n_valid - nv), 0);
    chk("armed_no_start", 32'(n_fs), 3);

    cap_en = 1'b1;
    vs_pulse();
    chk("f7_start", 32'(n_fs), 4);
    href = 1'b1; data = 8'h99;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_valid", 32'(o_v), 0);
    chk("mrst_vsync", 32'(o_vs), 0);
    chk("mrst_href", 32'(o_hs), 0);
    chk("mrst_data", 32'(o_d), 0);
    chk("mrst_px", 32'(o_px), 0);
    chk("mrst_py", 32'(o_py), 0);
    chk("mrst_fs", 32'(o_fs), 0);
    chk("mrst_fe", 32'(o_fe), 0);
    chk("mrst_cnt", 32'(o_fc), 0);
    chk("mrst_err", 32'(o_err), 0);
    rst = 1'b0; href = 1'b0;
    repeat (2) @(negedge clk);

    for (int f = 0; f < 2; f++) begin
      vs_pulse();
      send_line(4, 8'h30, 8'h01, 0, 1'b0, 0, 0, 0, 0);
    end
    chk("rewait_no_start", 32'(n_fs), 4);
    vs_pulse();
    chk("f10_start", 32'(n_fs), 5);
    chk("f10_frame_cnt", 32'(o_fc), 0);
    send_line(4, 8'h20, 8'h01, 0, 1'b1, 0, 0, 0, 0);
    vs_pulse();
    chk("f11_frame_cnt", 32'(o_fc), 1);
    chk("f11_frame_end", 32'(n_fe), 4);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
